// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous VRAM between the display fetch path and a host port.
// Read latency is fixed at 3 cycles for both owners; host writes finish at N+1 with no response.
// Display always wins the grant; host_ready = !disp_req, so the host holds its request until accepted.
//
// Optional feature: define VRAM_ARB_STALL_CNT_EN to add host_stall_cnt, a saturating
// count of cycles with host_valid && !host_ready, cleared only by reset.
//
// Ports:
//   clk, reset        pixel clock; asynchronous active-high reset
//   disp_req/addr     display read request (one word per asserted cycle)
//   disp_data/valid   display read response, single-cycle valid pulse, data held
//   host_valid/ready  host handshake; host_we selects write (1) or read (0)
//   host_addr/wdata   host request payload
//   host_rdata/rvalid host read response, single-cycle valid pulse, data held
//   mem_addr/we/wdata registered VRAM command; mem_rdata returns one cycle later
//   host_stall_cnt    (VRAM_ARB_STALL_CNT_EN only) saturating host stall counter
module vga_vram_arbiter #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_req,
  input  logic [ADDR_BITS-1:0] disp_addr,
  output logic [DATA_BITS-1:0] disp_data,
  output logic                 disp_valid,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_wdata,
  output logic [DATA_BITS-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
`ifdef VRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]          host_stall_cnt
`endif
);

  typedef enum logic {OWN_DISP = 1'b0, OWN_HOST = 1'b1} owner_e;

  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  // Tag stage 1 travels with the command (N+1), stage 2 with mem_rdata (N+2).
  logic                 t1_vld_q, t1_vld_d, t2_vld_q, t2_vld_d;
  owner_e               t1_own_q, t1_own_d, t2_own_q, t2_own_d;
  logic [DATA_BITS-1:0] disp_data_q, disp_data_d, host_rdata_q, host_rdata_d;
  logic                 disp_valid_q, disp_valid_d, host_rvalid_q, host_rvalid_d;
  logic                 host_grant;

  always_comb begin
    host_ready    = !disp_req && !reset;
    host_grant    = host_valid && host_ready;

    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    t1_vld_d      = 1'b0;
    t1_own_d      = OWN_DISP;

    if (disp_req) begin
      mem_addr_d = disp_addr;
      t1_vld_d   = 1'b1;
    end else if (host_grant) begin
      mem_addr_d = host_addr;
      mem_we_d   = host_we;
      t1_own_d   = OWN_HOST;
      // Writes complete in the RAM and never enter the response pipeline.
      t1_vld_d   = !host_we;
      if (host_we) begin
        mem_wdata_d = host_wdata;
      end
    end

    t2_vld_d      = t1_vld_q;
    t2_own_d      = t1_own_q;

    disp_valid_d  = t2_vld_q && (t2_own_q == OWN_DISP);
    host_rvalid_d = t2_vld_q && (t2_own_q == OWN_HOST);
    disp_data_d   = disp_valid_d  ? mem_rdata : disp_data_q;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      t1_vld_q      <= 1'b0;
      t1_own_q      <= OWN_DISP;
      t2_vld_q      <= 1'b0;
      t2_own_q      <= OWN_DISP;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      t1_vld_q      <= t1_vld_d;
      t1_own_q      <= t1_own_d;
      t2_vld_q      <= t2_vld_d;
      t2_own_q      <= t2_own_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (host_valid && !host_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign host_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Randomised bench for vga_vram_arbiter with a transaction-level reference model.
// The model keeps a shadow memory and a queue of expected responses due 3 cycles after grant.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_vga_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] host_stall_cnt;
`endif

  always #5 clk = ~clk;

  vga_vram_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STALL_CNT_EN
    , .host_stall_cnt(host_stall_cnt)
`endif
  );

  // Synchronous single-port VRAM, read-before-write on the same edge.
  logic [15:0] vram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  typedef struct {
    bit          own_host;
    logic [15:0] dat;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_addr = '0;
  bit          exp_we = 1'b0;
  logic [15:0] exp_wdata = '0;
  logic [15:0] exp_dd = '0;
  logic [15:0] exp_hd = '0;
  bit          host_acc = 1'b0;
  int          stall_exp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then apply the grant rule.
  task automatic tick();
    bit   dv, hv;
    rsp_t r;
    @(negedge clk);
    if (reset) begin
      check_eq("rst_host_ready", host_ready, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_disp_valid", disp_valid, 0);
      check_eq("rst_host_rvalid", host_rvalid, 0);
`ifdef VRAM_ARB_STALL_CNT_EN
      check_eq("rst_stall_cnt", host_stall_cnt, 0);
`endif
      rsp_q.delete();
      exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
      exp_dd = '0; exp_hd = '0; host_acc = 1'b0; stall_exp = 0;
    end else begin
      check_eq("host_ready", host_ready, !disp_req);
      check_eq("mem_we", mem_we, exp_we);
      check_eq("mem_addr", mem_addr, exp_addr);
      if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
      dv = 1'b0; hv = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front();
        if (r.own_host) begin hv = 1'b1; exp_hd = r.dat; end
        else            begin dv = 1'b1; exp_dd = r.dat; end
      end
      check_eq("disp_valid", disp_valid, dv);
      check_eq("host_rvalid", host_rvalid, hv);
      check_eq("disp_data", disp_data, exp_dd);
      check_eq("host_rdata", host_rdata, exp_hd);
`ifdef VRAM_ARB_STALL_CNT_EN
      check_eq("stall_cnt", host_stall_cnt, stall_exp);
      if (host_valid && disp_req && stall_exp < 65535) stall_exp++;
`endif
      host_acc = 1'b0;
      exp_we   = 1'b0;
      if (disp_req) begin
        exp_addr = disp_addr;
        rsp_q.push_back('{1'b0, ref_mem[disp_addr], cyc + 3});
      end else if (host_valid) begin
        host_acc = 1'b1;
        exp_addr = host_addr;
        if (host_we) begin
          exp_we = 1'b1;
          exp_wdata = host_wdata;
          ref_mem[host_addr] = host_wdata;
        end else begin
          rsp_q.push_back('{1'b1, ref_mem[host_addr], cyc + 3});
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_disp_valid"}, disp_valid, 0);
    check_eq({tag, "_host_rvalid"}, host_rvalid, 0);
    check_eq({tag, "_disp_data"}, disp_data, 0);
    check_eq({tag, "_host_rdata"}, host_rdata, 0);
    check_eq({tag, "_host_ready"}, host_ready, 0);
  endtask

  initial begin
    int nw, c;
    for (int i = 0; i < 65536; i++) begin
      vram[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    host_valid = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #1;
    check_reset_outputs("init");
    repeat (2) tick();
    host_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Host write with no display traffic.
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'hBEEF;
    tick();
    check_eq("t1_accept", host_acc, 1);
    host_valid = 1'b0;
    repeat (4) tick();

    // Host read back of the same word.
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    tick();
    host_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_eq("t2_rvalid", host_rvalid, 1);
    check_eq("t2_rdata", host_rdata, 16'hBEEF);
    @(posedge clk); #1; cyc++;
    exp_hd = 16'hBEEF;
    rsp_q.delete();
    repeat (2) tick();

    // Display and host collide: display first, host on the next idle cycle.
    disp_req = 1'b1; disp_addr = 16'h0123;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    tick();
    check_eq("t3_host_blocked", host_acc, 0);
    disp_req = 1'b0;
    tick();
    check_eq("t3_host_late", host_acc, 1);
    host_valid = 1'b0;
    repeat (6) tick();

    // Periodic display fetches against a 100-write host stream.
    nw = 0; c = 0;
    while (nw < 100 && c < 2000) begin
      disp_req = (c % 4 == 0);
      disp_addr = 16'($urandom_range(0, 255));
      if (host_valid && host_acc) begin nw++; host_valid = 1'b0; end
      if (!host_valid && nw < 100) begin
        host_valid = 1'b1; host_we = 1'b1;
        host_addr = 16'($urandom_range(0, 255));
        host_wdata = 16'($urandom);
      end
      tick();
      c++;
    end
    check_eq("t4_writes", nw, 100);
    host_valid = 1'b0; disp_req = 1'b0;
    repeat (5) tick();
    for (int a = 0; a < 256; a++) check_eq("t4_vram", vram[a], ref_mem[a]);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      disp_req = ($urandom_range(0, 2) == 0);
      disp_addr = 16'($urandom_range(0, 255));
      if (host_valid && host_acc) host_valid = 1'b0;
      if (!host_valid && $urandom_range(0, 1) == 1) begin
        host_valid = 1'b1; host_we = 1'($urandom_range(0, 1));
        host_addr = 16'($urandom_range(0, 255));
        host_wdata = 16'($urandom);
      end
      tick();
    end
    host_valid = 1'b0; disp_req = 1'b0;
    repeat (6) tick();

    // Reset one cycle after a host read grant: the response must never appear.
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
    tick();
    host_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5");
    repeat (2) tick();
    host_valid = 1'b0;
    reset = 1'b0;
    repeat (6) tick();

`ifdef VRAM_ARB_STALL_CNT_EN
    reset = 1'b1; tick(); reset = 1'b0; tick();
    disp_req = 1'b1; host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0001;
    repeat (5) tick();
    disp_req = 1'b0; host_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_stall5", host_stall_cnt, 5);
    @(posedge clk); #1; cyc++;
    disp_req = 1'b1; host_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      disp_addr = 16'($urandom_range(0, 255));
      tick();
    end
    disp_req = 1'b0; host_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_saturate", host_stall_cnt, 16'hFFFF);
    @(posedge clk); #1; cyc++;
    rsp_q.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
